// File: rtl/frame_write_ctrl.sv
// frame_write_ctrl: receives the rasterizer pixel stream and writes each pixel
// into the draw half of a double-buffered pixel memory. Draw and display
// banks swap on the first vblank after the rasterizer reports a full frame.
module frame_write_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_rd_en,
  input  logic [9:0]        frame_x,
  input  logic [8:0]        frame_y,
  input  logic [2:0]        px_color,
  input  logic              raster_done,
  input  logic              vblank,
  output logic              frame_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  output logic              disp_bank,
  output logic [15:0]       drop_count
);

  localparam int         IDX_W = ADDR_W - 1;
  localparam logic [9:0] X_LIM = 10'(H_RES);
  localparam logic [8:0] Y_LIM = 9'(V_RES);

  typedef enum logic [1:0] {
    ST_DRAW      = 2'd0,
    ST_WAIT_SWAP = 2'd1,
    ST_SWAP      = 2'd2
  } state_t;

  // Linear pixel index y*640 + x built from shifts so no multiplier is needed.
  function automatic logic [IDX_W-1:0] pixel_index(input logic [9:0] x,
                                                   input logic [8:0] y);
    return (IDX_W'(y) << 9) + (IDX_W'(y) << 7) + IDX_W'(x);
  endfunction

  // Saturating increment for the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state_q, state_d;
  logic              disp_bank_q, disp_bank_d;
  logic              frame_ready_q, frame_ready_d;
  logic [15:0]       drop_count_q, drop_count_d;

  logic              vld_p0_q, vld_p0_d;
  logic [IDX_W-1:0]  idx_p0_q, idx_p0_d;
  logic [2:0]        color_p0_q, color_p0_d;
  logic              bank_p0_q, bank_p0_d;

  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        mem_wdata_q, mem_wdata_d;

  logic              in_range;
  logic              accept;
  logic              drop;

  // Classify each strobe as an accepted write or a dropped pixel.
  always_comb begin
    in_range = (frame_x < X_LIM) && (frame_y < Y_LIM);
    accept   = frame_rd_en && (state_q == ST_DRAW) && in_range;
    drop     = frame_rd_en && !accept;
  end

  // Frame FSM: draw, wait for vblank after raster_done, one-cycle bank swap.
  always_comb begin
    state_d      = state_q;
    disp_bank_d  = disp_bank_q;
    drop_count_d = drop_count_q;
    case (state_q)
      ST_DRAW:      if (raster_done) state_d = ST_WAIT_SWAP;
      ST_WAIT_SWAP: if (vblank)      state_d = ST_SWAP;
      ST_SWAP: begin
        disp_bank_d = ~disp_bank_q;
        state_d     = ST_DRAW;
      end
      default:      state_d = ST_DRAW;
    endcase
    frame_ready_d = (state_d == ST_DRAW);
    if (drop) drop_count_d = sat_inc16(drop_count_q);
  end

  // Write pipeline: p0 captures an accepted pixel with the draw bank of that
  // cycle, p1 presents it to memory. Capturing the bank at acceptance means a
  // write from the last DRAW cycle can never land in the new display bank.
  always_comb begin
    vld_p0_d    = accept;
    idx_p0_d    = idx_p0_q;
    color_p0_d  = color_p0_q;
    bank_p0_d   = bank_p0_q;
    if (accept) begin
      idx_p0_d   = pixel_index(frame_x, frame_y);
      color_p0_d = px_color;
      bank_p0_d  = ~disp_bank_q;
    end
    // p0 -> p1
    mem_we_d    = vld_p0_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (vld_p0_q) begin
      mem_addr_d  = {bank_p0_q, idx_p0_q};
      mem_wdata_d = color_p0_q;
    end
  end

  // All state registers; async reset also cancels any in-flight write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_DRAW;
      disp_bank_q   <= 1'b1;
      frame_ready_q <= 1'b0;
      drop_count_q  <= 16'd0;
      vld_p0_q      <= 1'b0;
      idx_p0_q      <= '0;
      color_p0_q    <= 3'd0;
      bank_p0_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      disp_bank_q   <= disp_bank_d;
      frame_ready_q <= frame_ready_d;
      drop_count_q  <= drop_count_d;
      vld_p0_q      <= vld_p0_d;
      idx_p0_q      <= idx_p0_d;
      color_p0_q    <= color_p0_d;
      bank_p0_q     <= bank_p0_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_bank   = disp_bank_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Scoreboard bench for frame_write_ctrl: directed pixel strobes push their
// hand-computed memory writes; a negedge monitor checks every mem_we cycle.
module tb_frame_write_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_rd_en;
  logic [9:0]  frame_x;
  logic [8:0]  frame_y;
  logic [2:0]  px_color;
  logic        raster_done;
  logic        vblank;
  logic        frame_ready;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        disp_bank;
  logic [15:0] drop_count;

  typedef struct packed {
    logic [19:0] addr;
    logic [2:0]  data;
    logic [31:0] cyc;
  } wr_t;

  wr_t         sb[$];
  int          n_cmp;
  int          n_fail;
  logic [31:0] cyc;

  frame_write_ctrl #(.H_RES(640), .V_RES(480), .ADDR_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_rd_en (frame_rd_en),
    .frame_x     (frame_x),
    .frame_y     (frame_y),
    .px_color    (px_color),
    .raster_done (raster_done),
    .vblank      (vblank),
    .frame_ready (frame_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .disp_bank   (disp_bank),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required none", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr",  32'(mem_addr),  32'(e.addr));
        chk("wr_data",  32'(mem_wdata), 32'(e.data));
        chk("wr_cycle", cyc,            e.cyc);
      end
    end
  end

  // Drive one cycle of inputs from a negedge, return at the following negedge.
  task automatic step(input logic en, input logic [9:0] x, input logic [8:0] y,
                      input logic [2:0] c, input logic rd, input logic vb,
                      input logic exp_wr, input logic [19:0] exp_addr);
    wr_t e;
    frame_rd_en = en;
    frame_x     = x;
    frame_y     = y;
    px_color    = c;
    raster_done = rd;
    vblank      = vb;
    if (exp_wr) begin
      e.addr = exp_addr;
      e.data = c;
      e.cyc  = cyc + 32'd2;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    frame_rd_en = 1'b0;
    raster_done = 1'b0;
    vblank      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    frame_rd_en = 1'b0;
    frame_x     = 10'd0;
    frame_y     = 9'd0;
    px_color    = 3'd0;
    raster_done = 1'b0;
    vblank      = 1'b0;
    rst         = 1'b1;
    #2 rst = 1'b0;
    idle(3);

    // Reset values
    chk("rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("rst_mem_we",      32'(mem_we),      32'd0);
    chk("rst_mem_addr",    32'(mem_addr),    32'd0);
    chk("rst_mem_wdata",   32'(mem_wdata),   32'd0);
    chk("rst_disp_bank",   32'(disp_bank),   32'd1);
    chk("rst_drop_count",  32'(drop_count),  32'd0);
    rst = 1'b1;

    // 1: origin pixel into bank 0
    step(1'b1, 10'd0, 9'd0, 3'd5, 1'b0, 1'b0, 1'b1, 20'h00000);
    chk("t1_frame_ready", 32'(frame_ready), 32'd1);
    chk("t1_disp_bank",   32'(disp_bank),   32'd1);

    // 2a: corner pixel in bank 0
    step(1'b1, 10'd639, 9'd479, 3'd2, 1'b0, 1'b0, 1'b1, 20'h4AFFF);

    // 3: out-of-range pixels are dropped
    step(1'b1, 10'd640, 9'd0,   3'd1, 1'b0, 1'b0, 1'b0, 20'h0);
    step(1'b1, 10'd0,   9'd480, 3'd1, 1'b0, 1'b0, 1'b0, 20'h0);
    chk("t3_drop_count", 32'(drop_count), 32'd2);

    // 4: raster_done, strobe while waiting, vblank 50 cycles later
    step(1'b0, 10'd0, 9'd0, 3'd0, 1'b1, 1'b0, 1'b0, 20'h0);
    chk("t4_ready_low", 32'(frame_ready), 32'd0);
    step(1'b1, 10'd10, 9'd10, 3'd3, 1'b0, 1'b0, 1'b0, 20'h0);
    chk("t4_drop_wait", 32'(drop_count), 32'd3);
    idle(50);
    step(1'b0, 10'd0, 9'd0, 3'd0, 1'b0, 1'b1, 1'b0, 20'h0);
    chk("t4_swap_bank_old", 32'(disp_bank),   32'd1);
    chk("t4_swap_ready",    32'(frame_ready), 32'd0);
    idle(1);
    chk("t4_bank_new",  32'(disp_bank),   32'd0);
    chk("t4_ready_hi",  32'(frame_ready), 32'd1);

    // 2b: same corner pixel now lands in bank 1
    step(1'b1, 10'd639, 9'd479, 3'd2, 1'b0, 1'b0, 1'b1, 20'hCAFFF);

    // 5: raster_done with vblank together waits for the next vblank
    step(1'b0, 10'd0, 9'd0, 3'd0, 1'b1, 1'b1, 1'b0, 20'h0);
    chk("t5_ready_low", 32'(frame_ready), 32'd0);
    idle(5);
    chk("t5_bank_held", 32'(disp_bank),   32'd0);
    chk("t5_still_wait", 32'(frame_ready), 32'd0);
    step(1'b1, 10'd5, 9'd5, 3'd4, 1'b0, 1'b1, 1'b0, 20'h0);
    chk("t5_drop_vblank", 32'(drop_count), 32'd4);
    idle(1);
    chk("t5_bank_new", 32'(disp_bank),   32'd1);
    chk("t5_ready_hi", 32'(frame_ready), 32'd1);

    // Strobe with raster_done: pixel is still written into the old draw bank
    step(1'b1, 10'd1, 9'd2, 3'd6, 1'b1, 1'b0, 1'b1, 20'h00501);
    chk("t5b_ready_low", 32'(frame_ready), 32'd0);
    idle(2);
    step(1'b0, 10'd0, 9'd0, 3'd0, 1'b0, 1'b1, 1'b0, 20'h0);
    idle(1);
    chk("t5b_bank", 32'(disp_bank), 32'd0);

    // 6: async reset in WAIT_SWAP with a write in flight
    step(1'b1, 10'd3, 9'd0, 3'd7, 1'b1, 1'b0, 1'b0, 20'h0);
    #1 rst = 1'b0;
    #1;
    chk("t6_mem_we",      32'(mem_we),      32'd0);
    chk("t6_disp_bank",   32'(disp_bank),   32'd1);
    chk("t6_frame_ready", 32'(frame_ready), 32'd0);
    chk("t6_drop_count",  32'(drop_count),  32'd0);
    chk("t6_mem_addr",    32'(mem_addr),    32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    chk("t6_ready_again", 32'(frame_ready), 32'd1);
    step(1'b1, 10'd639, 9'd0, 3'd1, 1'b0, 1'b0, 1'b1, 20'h0027F);
    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
